// File: rtl/conv_bias_add_if.sv
// Stream bundle for conv_bias_add: accumulator beats in, quantized results out.
// The slave modport is the block's view; the master modport is the producer/consumer side.
interface conv_bias_add_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CH_W  = 6
) ();
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] in_acc;
  logic [CH_W-1:0]  in_ch;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CH_W-1:0]  out_ch;

  modport master (
    output in_valid, in_acc, in_ch, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_acc, in_ch, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/conv_bias_add.sv
// Bias add, optional round/shift and saturation after the conv accumulator, fed by a bias SRAM.
// Define CONV_BIAS_RELU_EN to clamp the saturated result at zero (ReLU).
module conv_bias_add #(
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned BIAS_W = 17,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned CH_NUM = 48,
  parameter int unsigned SHIFT  = 0,
  localparam int unsigned CH_W  = $clog2(CH_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  conv_bias_add_if.slave    bus,
  output logic [CH_W-1:0]   bias_addr,
  input  logic [BIAS_W-1:0] bias_dout,
  output logic              err_ch
);

  // One spare bit for the add and one for the rounding increment.
  localparam int unsigned RND_W = ACC_W + 2;

  logic             s1_valid;
  logic [ACC_W-1:0] s1_acc;
  logic [CH_W-1:0]  s1_ch;
  logic             s1_oor;

  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [CH_W-1:0]  out_ch_q;
  logic             err_ch_q;

  logic adv;
  logic in_ready;
  logic accept;
  logic in_oor;

  assign adv       = !out_valid_q || bus.out_ready;
  assign in_ready  = !s1_valid || adv;
  assign accept    = bus.in_valid && in_ready;
  assign in_oor    = 32'(bus.in_ch) >= CH_NUM;
  // Holding the address on stall keeps bias_dout aligned with S1 every cycle.
  assign bias_addr = in_ready ? bus.in_ch : s1_ch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_acc   <= '0;
      s1_ch    <= '0;
      s1_oor   <= 1'b0;
      err_ch_q <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= bus.in_valid;
      end
      if (accept) begin
        s1_acc <= bus.in_acc;
        s1_ch  <= bus.in_ch;
        s1_oor <= in_oor;
        if (in_oor) begin
          err_ch_q <= 1'b1;
        end
      end
    end
  end

  logic [BIAS_W-1:0]       bias_eff;
  logic signed [RND_W-1:0] sum_ext;
  logic signed [RND_W-1:0] shifted;
  logic [RND_W-OUT_W:0]    hi_bits;
  logic [OUT_W-1:0]        sat;
  logic [OUT_W-1:0]        result;

  assign bias_eff = s1_oor ? '0 : bias_dout;
  assign sum_ext  = {{(RND_W - ACC_W){s1_acc[ACC_W-1]}}, s1_acc}
                  + {{(RND_W - BIAS_W){bias_eff[BIAS_W-1]}}, bias_eff};

  if (SHIFT > 0) begin : g_shift
    logic signed [RND_W-1:0] rnd_sum;
    assign rnd_sum = sum_ext + (RND_W'(1) << (SHIFT - 1));
    assign shifted = rnd_sum >>> SHIFT;
  end else begin : g_no_shift
    assign shifted = sum_ext;
  end

  // In range iff every bit above the output sign bit matches it.
  assign hi_bits = shifted[RND_W-1:OUT_W-1];

  always_comb begin
    sat = shifted[OUT_W-1:0];
    if (!((&hi_bits) || !(|hi_bits))) begin
      sat = shifted[RND_W-1] ? {1'b1, {(OUT_W - 1){1'b0}}} : {1'b0, {(OUT_W - 1){1'b1}}};
    end
  end

`ifdef CONV_BIAS_RELU_EN
  assign result = sat[OUT_W-1] ? '0 : sat;
`else
  assign result = sat;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_data_q <= result;
        out_ch_q   <= s1_ch;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign err_ch        = err_ch_q;

endmodule

// File: tb/tb_conv_bias_add.sv
// Scoreboard bench for conv_bias_add: a SHIFT=0 instance and a SHIFT=2 instance share clk/rst.
// Expected results are queued at acceptance and popped by per-instance output monitors.
module tb_conv_bias_add;

  logic clk;
  logic rst;

  logic [5:0]  addr0, addr2;
  logic [16:0] dout0, dout2;
  logic        err0, err2;
  logic [16:0] mem0 [64];
  logic [16:0] mem2 [64];

  conv_bias_add_if #(.ACC_W(24), .OUT_W(16), .CH_W(6)) b0 ();
  conv_bias_add_if #(.ACC_W(24), .OUT_W(16), .CH_W(6)) b2 ();

  conv_bias_add #(.ACC_W(24), .BIAS_W(17), .OUT_W(16), .CH_NUM(48), .SHIFT(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (b0.slave),
    .bias_addr (addr0),
    .bias_dout (dout0),
    .err_ch    (err0)
  );

  conv_bias_add #(.ACC_W(24), .BIAS_W(17), .OUT_W(16), .CH_NUM(48), .SHIFT(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (b2.slave),
    .bias_addr (addr2),
    .bias_dout (dout2),
    .err_ch    (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bias SRAMs: synchronous read, one cycle latency.
  always @(posedge clk) begin
    dout0 <= mem0[addr0];
    dout2 <= mem2[addr2];
  end

`ifdef CONV_BIAS_RELU_EN
  localparam int ExpSatNeg = 0;
  localparam int ExpRndNeg = 0;
`else
  localparam int ExpSatNeg = -32768;
  localparam int ExpRndNeg = -2;
`endif

  typedef struct {
    logic [15:0] data;
    logic [5:0]  ch;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;

  int checks = 0;
  int errors = 0;
  logic [5:0] last_acc_ch;
  int stall_exp[10] = '{1000, 1011, 1022, 1033, 1044, 1004, 1066, 1077, 1088, 1099};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && b0.out_valid && b0.out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out0: got data %0d ch %0d expected no output",
                 $signed(b0.out_data), b0.out_ch);
      end else begin
        e0 = q0.pop_front();
        check({e0.name, "_data"}, int'($signed(b0.out_data)), int'($signed(e0.data)));
        check({e0.name, "_ch"}, int'(b0.out_ch), int'(e0.ch));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b2.out_valid && b2.out_ready) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out2: got data %0d ch %0d expected no output",
                 $signed(b2.out_data), b2.out_ch);
      end else begin
        e2 = q2.pop_front();
        check({e2.name, "_data"}, int'($signed(b2.out_data)), int'($signed(e2.data)));
        check({e2.name, "_ch"}, int'(b2.out_ch), int'(e2.ch));
      end
    end
  end

  task automatic send(input bit sel, input int acc, input int ch, input int exp,
                      input string name);
    int   n;
    exp_t e;
    e.data = 16'(exp);
    e.ch   = 6'(ch);
    e.name = name;
    if (sel) begin
      b2.in_valid = 1'b1;
      b2.in_acc   = 24'(acc);
      b2.in_ch    = 6'(ch);
    end else begin
      b0.in_valid = 1'b1;
      b0.in_acc   = 24'(acc);
      b0.in_ch    = 6'(ch);
    end
    n = 0;
    @(negedge clk);
    while (!(sel ? b2.in_ready : b0.in_ready) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got in_ready 0 for 50 cycles expected 1", name);
    end else begin
      @(posedge clk);
      if (sel) q2.push_back(e);
      else q0.push_back(e);
      last_acc_ch = 6'(ch);
      #1;
    end
    if (sel) b2.in_valid = 1'b0;
    else b0.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q2.size() != 0) && n < 100) begin
      n++;
      @(posedge clk);
    end
    if (q0.size() != 0 || q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d results outstanding expected 0", name,
               q0.size() + q2.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  resid;
    bit  saw_stall;

    for (int i = 0; i < 64; i++) begin
      mem0[i] = '0;
      mem2[i] = '0;
    end
    mem0[1] = 17'd10;
    mem0[2] = 17'd20;
    mem0[3] = 17'd30;
    mem0[4] = 17'd40;
    mem0[5] = 17'h1FFFF;
    mem0[6] = 17'd60;
    mem0[7] = 17'd70;
    mem0[8] = 17'd80;
    mem0[9] = 17'd90;
    mem0[50] = 17'd123;
    mem2[1] = 17'd6;

    b0.in_valid = 1'b0; b0.in_acc = '0; b0.in_ch = '0; b0.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.in_acc = '0; b2.in_ch = '0; b2.out_ready = 1'b1;
    rst = 1'b1;
    #7;
    check("rst_out_valid", int'(b0.out_valid), 0);
    check("rst_out_data", int'(b0.out_data), 0);
    check("rst_out_ch", int'(b0.out_ch), 0);
    check("rst_err_ch", int'(err0), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("post_rst_in_ready", int'(b0.in_ready), 1);

    // Latency: accept edge, then one cycle in S1, then output visible.
    send(0, 100, 5, 99, "bias_neg1");
    @(negedge clk);
    check("latency_cycle1_out_valid", int'(b0.out_valid), 0);
    @(negedge clk);
    check("latency_cycle2_out_valid", int'(b0.out_valid), 1);
    drain("basic");

    send(0, 40000, 0, 32767, "sat_pos");
    send(0, -40000, 0, ExpSatNeg, "sat_neg");
    drain("sat");

    send(1, 0, 1, 2, "shift_round_pos");
    send(1, -13, 1, ExpRndNeg, "shift_round_neg");
    drain("shift");

    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(0, 1000 + i, i, stall_exp[i], $sformatf("stall_beat%0d", i));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 b0.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!b0.in_ready) begin
            saw_stall = 1'b1;
            check("stall_bias_addr_hold", int'(addr0), int'(last_acc_ch));
          end
        end
        @(posedge clk);
        #1 b0.out_ready = 1'b1;
      end
    join
    check("stall_in_ready_drop", int'(saw_stall), 1);
    drain("stall");

    check("err_ch_before_oor", int'(err0), 0);
    send(0, 7, 50, 7, "oor_ch");
    check("err_ch_set", int'(err0), 1);
    for (int i = 0; i < 20; i++) begin
      send(0, 0, 0, 0, "after_oor");
    end
    drain("oor");
    check("err_ch_sticky", int'(err0), 1);
    #2 rst = 1'b1;
    #1 check("err_ch_cleared", int'(err0), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Two beats in flight, reset lands mid-cycle.
    send(0, 11, 2, 31, "flight_a");
    send(0, 12, 3, 42, "flight_b");
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", int'(b0.out_valid), 0);
    check("async_rst_out_data", int'(b0.out_data), 0);
    q0.delete();
    q2.delete();
    #10;
    @(posedge clk);
    #1 rst = 1'b0;
    resid = 0;
    repeat (10) begin
      @(negedge clk);
      if (b0.out_valid) resid++;
    end
    check("no_residual_output", resid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_bias_add.md
Name: conv_bias_add

Overview:
- Post-accumulation stage of the convolution datapath, downstream of the 48x17 bias SRAM.
- Takes per-channel convolution accumulator results on a valid/ready stream and reads the matching bias word from the SRAM's synchronous read port (1-cycle latency).
- Adds the bias, then rounds/shifts and saturates the result.
- Emits the quantized result with its channel index on a valid/ready stream toward the activation/output buffer.

Parameters:
- ACC_W, 24, accumulator input width, signed two's complement
- BIAS_W, 17, bias word width, signed; matches the bias SRAM word
- OUT_W, 16, output width, signed
- CH_NUM, 48, number of channels (bias SRAM depth)
- SHIFT, 0, arithmetic right shift applied after the bias add; 0 = no shift

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_acc  input  ACC_W  signed accumulator value
- in_ch  input  $clog2(CH_NUM)  channel index of the beat
- bias_addr  output  $clog2(CH_NUM)  read address to the bias SRAM (combinational)
- bias_dout  input  BIAS_W  bias SRAM read data, valid the cycle after bias_addr is sampled
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts when out_valid && out_ready
- out_data  output  OUT_W  signed saturated result
- out_ch  output  $clog2(CH_NUM)  channel index travelling with out_data
- err_ch  output  1  sticky flag: an accepted beat had in_ch >= CH_NUM

Behaviour:
- Reset (async, active-high): s1_valid=0, out_valid=0, out_data=0, out_ch=0, err_ch=0. In-flight beats are discarded; in_ready=1 after reset deasserts.
- Pipeline stages:
  - S1 holds acc/ch while the bias read is in flight.
  - The output register holds the result.
- Stall and ready logic:
  - adv = !out_valid || out_ready.
  - in_ready = !s1_valid || adv.
- bias_addr = in_ready ? in_ch : s1_ch.
  - On stall the address is held, so bias_dout stays valid for S1 on every cycle.
- Accept at edge N:
  - S1 loads in_acc/in_ch and s1_valid=1.
  - The SRAM samples in_ch at the same edge.
- Edge N+1, if adv:
  - Output register loads result(s1_acc, bias_dout) and out_ch=s1_ch.
  - out_valid=s1_valid.
- Latency: out_valid is asserted 2 cycles after acceptance. Throughput: 1 beat/cycle with out_ready held high.
- Arithmetic:
  - sum = sext(acc) + sext(bias), computed at ACC_W+1 bits with no overflow.
  - If SHIFT>0: sum += 1<<(SHIFT-1) (round half up), then arithmetic shift right by SHIFT.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Out-of-range channel (in_ch >= CH_NUM):
  - Bias is forced to 0 for that beat.
  - err_ch is set at the S1 load edge and stays high until reset.
  - The beat still flows through.
- out_valid, out_data and out_ch hold stable while out_valid && !out_ready.
- Accept and drain in the same cycle (full pipeline with out_ready=1): no bubble, no lost beat.
- The bias SRAM must not be written while a beat is in S1. This is a system-level rule; the block does not check it.

Optional Feature:
- Macro CONV_BIAS_RELU_EN.
- When defined: the saturated result is clamped at 0 from below (ReLU), so out_data >= 0.
- When undefined: signed saturated output only.
- Timing and handshake are identical in both builds.

Test Plan:
- Bias[5]=17'h1FFFF (-1), in_acc=100, ch=5 -> out_data=99, out_ch=5, out_valid exactly 2 cycles after accept.
- Bias[0]=0; in_acc=40000 -> 32767; in_acc=-40000 -> -32768. With CONV_BIAS_RELU_EN, the -40000 case gives 0.
- SHIFT=2, bias[1]=6, in_acc=0 -> 2, i.e. (6+2)>>2; in_acc=-13 -> -2, i.e. (-7+2)>>2.
- 10 back-to-back beats ch=0..9, out_ready held low 3 cycles mid-stream:
  - in_ready drops.
  - bias_addr holds s1_ch.
  - All 10 results are in order and correct, with no drop or duplicate.
- in_ch=50 with in_acc=7 -> out_data=7, err_ch=1 and still 1 after 20 further valid beats; rst -> err_ch=0.
- Assert rst asynchronously (not on a clock edge) with 2 beats in flight -> out_valid=0 and out_data=0 immediately, with no residual output after release.
